exec_alu: RTL and testbench

- Single-cycle integer execution unit inside the reservation station.
- Each cycle it takes at most one operand-ready instruction (opcode class, two operand values, ROB tag) and returns a registered result one cycle later, tagged for the CDB.
- On JALR it also sends the computed jump target to instruction fetch so fetch can resume.

---
 rtl/exec_alu_if.sv | 30 +++
 rtl/exec_alu.sv | 123 ++++++++++++
 tb/tb_exec_alu.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/exec_alu_if.sv
// exec_alu_if: issue/result bundle between the reservation station and the integer ALU
interface exec_alu_if #(
    parameter int VAL_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 4,
    parameter int OP_WIDTH     = 7
);
    logic                    execute;
    logic                    flush;
    logic [OP_WIDTH-1:0]     op_type;
    logic [VAL_WIDTH-1:0]    val1;
    logic [VAL_WIDTH-1:0]    val2;
    logic [ROB_ID_WIDTH:0]   entry;
    logic [ADDR_WIDTH-1:0]   nowPC;
    logic                    aluReady;
    logic [ROB_ID_WIDTH:0]   entry_out;
    logic [VAL_WIDTH-1:0]    val_out;
    logic [ADDR_WIDTH-1:0]   alu2if_pc;
    logic                    alu2if_con;

    modport master (
        output execute, flush, op_type, val1, val2, entry, nowPC,
        input  aluReady, entry_out, val_out, alu2if_pc, alu2if_con
    );

    modport slave (
        input  execute, flush, op_type, val1, val2, entry, nowPC,
        output aluReady, entry_out, val_out, alu2if_pc, alu2if_con
    );
endinterface

// File: rtl/exec_alu.sv
// exec_alu: single-cycle integer execution unit with registered CDB result and JALR redirect
module exec_alu #(
    parameter int VAL_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 4,
    parameter int OP_WIDTH     = 7
) (
    input  logic      clk,
    input  logic      rst_in,
    input  logic      rdy_in,
    exec_alu_if.slave bus
);
    localparam logic [2:0] CLS_UJ = 3'b000;
    localparam logic [2:0] CLS_R  = 3'b001;
    localparam logic [2:0] CLS_I  = 3'b010;
    localparam logic [2:0] CLS_BR = 3'b011;

    logic [2:0]            cls;
    logic [3:0]            sub;
    logic [VAL_WIDTH-1:0]  a, b, sum, diff, res;
    logic [4:0]            sh;
    logic                  eq, slt, ult, taken, is_jalr;

    logic                  ready_d, ready_q;
    logic                  con_d, con_q;
    logic [ROB_ID_WIDTH:0] entry_d, entry_q;
    logic [VAL_WIDTH-1:0]  val_d, val_q;
    logic [ADDR_WIDTH-1:0] pc_d, pc_q;

    // decode the opcode and compute the result of the instruction on the inputs
    always_comb begin
        cls     = bus.op_type[6:4];
        sub     = bus.op_type[3:0];
        a       = bus.val1;
        b       = bus.val2;
        sum     = a + b;
        diff    = a - b;
        sh      = b[4:0];
        eq      = a == b;
        slt     = $signed(a) < $signed(b);
        ult     = a < b;
        is_jalr = cls == CLS_I && sub == 4'd10;
        taken   = 1'b0;
        res     = '0;
        case (sub)
            4'd0:    taken = eq;
            4'd1:    taken = !eq;
            4'd4:    taken = slt;
            4'd5:    taken = !slt;
            4'd6:    taken = ult;
            4'd7:    taken = !ult;
            default: taken = 1'b0;
        endcase
        case (cls)
            CLS_UJ:  res = (sub >= 4'd1 && sub <= 4'd3) ? sum : '0;
            CLS_R, CLS_I: begin
                if (is_jalr) res = VAL_WIDTH'(bus.nowPC + ADDR_WIDTH'(4));
                else begin
                    case (sub)
                        4'd0:    res = sum;
                        4'd1:    res = (cls == CLS_I) ? sum : diff;
                        4'd2:    res = a << sh;
                        4'd3:    res = VAL_WIDTH'(slt);
                        4'd4:    res = VAL_WIDTH'(ult);
                        4'd5:    res = a ^ b;
                        4'd6:    res = a >> sh;
                        4'd7:    res = $signed(a) >>> sh;
                        4'd8:    res = a | b;
                        4'd9:    res = a & b;
                        default: res = '0;
                    endcase
                end
            end
            CLS_BR:  res = VAL_WIDTH'(taken);
            default: res = '0;
        endcase
    end

    // next output state: flush clears, stall holds, otherwise capture this cycle's issue
    always_comb begin
        ready_d = ready_q;
        con_d   = con_q;
        entry_d = entry_q;
        val_d   = val_q;
        pc_d    = pc_q;
        if (rdy_in && bus.flush) begin
            ready_d = 1'b0;
            con_d   = 1'b0;
            entry_d = '0;
            val_d   = '0;
            pc_d    = '0;
        end else if (rdy_in) begin
            ready_d = bus.execute;
            con_d   = bus.execute && is_jalr;
            entry_d = bus.execute ? bus.entry : entry_q;
            val_d   = bus.execute ? res : val_q;
            pc_d    = (bus.execute && is_jalr) ? ADDR_WIDTH'({sum[VAL_WIDTH-1:1], 1'b0}) : pc_q;
        end
    end

    // output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_in) begin
            ready_q <= 1'b0;
            con_q   <= 1'b0;
            entry_q <= '0;
            val_q   <= '0;
            pc_q    <= '0;
        end else begin
            ready_q <= ready_d;
            con_q   <= con_d;
            entry_q <= entry_d;
            val_q   <= val_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.aluReady   = ready_q;
    assign bus.alu2if_con = con_q;
    assign bus.entry_out  = entry_q;
    assign bus.val_out    = val_q;
    assign bus.alu2if_pc  = pc_q;
endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: vector table, corner sequences and random stimulus against a behavioural model
module tb_exec_alu;
    logic clk = 1'b0;
    logic rst_in, rdy_in;
    int   checks = 0;
    int   errors = 0;

    exec_alu_if bus ();
    exec_alu dut (.clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [6:0] JALR = 7'h2A;

    logic        m_rdy, m_con;
    logic [4:0]  m_ent;
    logic [31:0] m_val, m_pc;

    typedef struct {
        logic [6:0]  op;
        logic [31:0] v1, v2, pc;
        logic [31:0] exp_val;
        logic        exp_con;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [31:0] a, b, pc);
        int unsigned cls = op[6:4];
        int unsigned sub = op[3:0];
        int unsigned sh  = b % 32;
        longint      sa  = $signed(a);
        longint      sb  = $signed(b);
        longint      ua  = a;
        longint      ub  = b;
        if (cls == 0) return (sub >= 1 && sub <= 3) ? 32'(ua + ub) : 32'd0;
        if (cls == 1 || cls == 2) begin
            if (cls == 2 && sub == 10) return pc + 32'd4;
            if (cls == 2 && sub == 1) sub = 0;
            case (sub)
                0: return 32'(ua + ub);
                1: return 32'(ua - ub);
                2: return 32'(ua * (longint'(1) << sh));
                3: return (sa < sb) ? 32'd1 : 32'd0;
                4: return (ua < ub) ? 32'd1 : 32'd0;
                5: return a ^ b;
                6: return 32'(ua / (longint'(1) << sh));
                7: return 32'(sa >>> sh);
                8: return a | b;
                9: return a & b;
                default: return 32'd0;
            endcase
        end
        if (cls == 3) begin
            case (sub)
                0: return (ua == ub) ? 32'd1 : 32'd0;
                1: return (ua != ub) ? 32'd1 : 32'd0;
                4: return (sa < sb) ? 32'd1 : 32'd0;
                5: return (sa >= sb) ? 32'd1 : 32'd0;
                6: return (ua < ub) ? 32'd1 : 32'd0;
                7: return (ua >= ub) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, f, rd, ex, input logic [6:0] op,
                       input logic [31:0] a, b, input logic [4:0] e, input logic [31:0] pc);
        rst_in      = r;
        rdy_in      = rd;
        bus.flush   = f;
        bus.execute = ex;
        bus.op_type = op;
        bus.val1    = a;
        bus.val2    = b;
        bus.entry   = e;
        bus.nowPC   = pc;
        if (r || (rd && f)) begin
            m_rdy = 0; m_con = 0; m_ent = 0; m_val = 0; m_pc = 0;
        end else if (rd) begin
            m_rdy = ex;
            m_con = ex && op == JALR;
            if (ex) begin
                m_ent = e;
                m_val = ref_result(op, a, b, pc);
                if (op == JALR) m_pc = (a + b) & 32'hFFFF_FFFE;
            end
        end
        @(posedge clk);
        #1;
        check("aluReady", 32'(bus.aluReady), 32'(m_rdy));
        check("alu2if_con", 32'(bus.alu2if_con), 32'(m_con));
        check("entry_out", 32'(bus.entry_out), 32'(m_ent));
        check("val_out", bus.val_out, m_val);
        check("alu2if_pc", bus.alu2if_pc, m_pc);
    endtask

    task automatic add_vec(input logic [6:0] op, input logic [31:0] v1, v2, pc, ev,
                           input logic ec, input logic [31:0] ep);
        vec_t v;
        v.op = op; v.v1 = v1; v.v2 = v2; v.pc = pc; v.exp_val = ev; v.exp_con = ec; v.exp_pc = ep;
        tbl.push_back(v);
    endtask

    logic [6:0] ops[] = '{7'h01, 7'h02, 7'h03, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15,
                          7'h16, 7'h17, 7'h18, 7'h19, 7'h20, 7'h21, 7'h22, 7'h23, 7'h24,
                          7'h25, 7'h26, 7'h27, 7'h28, 7'h29, 7'h2A, 7'h30, 7'h31, 7'h34,
                          7'h35, 7'h36, 7'h37};

    initial begin
        add_vec(7'h10, 32'hFFFF_FFFF, 32'd2, 0, 32'h1, 0, 0);
        add_vec(7'h11, 32'd3, 32'd5, 0, 32'hFFFF_FFFE, 0, 0);
        add_vec(7'h17, 32'h8000_0000, 32'h24, 0, 32'hF800_0000, 0, 0);
        add_vec(7'h13, 32'hFFFF_FFFF, 32'd1, 0, 32'h1, 0, 0);
        add_vec(7'h14, 32'hFFFF_FFFF, 32'd1, 0, 32'h0, 0, 0);
        add_vec(7'h01, 32'h1234_5000, 32'd0, 0, 32'h1234_5000, 0, 0);
        add_vec(7'h02, 32'h1000, 32'h200, 0, 32'h1200, 0, 0);
        add_vec(7'h03, 32'd4, 32'h100, 0, 32'h104, 0, 0);
        add_vec(7'h34, 32'hFFFF_FFFF, 32'd1, 0, 32'h1, 0, 0);
        add_vec(7'h36, 32'hFFFF_FFFF, 32'd1, 0, 32'h0, 0, 0);
        add_vec(7'h30, 32'hFFFF_FFFF, 32'd1, 0, 32'h0, 0, 0);
        add_vec(7'h31, 32'hFFFF_FFFF, 32'd1, 0, 32'h1, 0, 0);
        add_vec(JALR, 32'h1003, 32'd4, 32'h80, 32'h84, 1, 32'h1006);
        add_vec(7'h21, 32'd5, 32'd3, 0, 32'h8, 0, 32'h1006);
        add_vec(7'h12, 32'd1, 32'h21, 0, 32'h2, 0, 32'h1006);
        add_vec(7'h15, 32'hF0, 32'hFF, 0, 32'h0F, 0, 32'h1006);
        add_vec(7'h35, 32'd1, 32'hFFFF_FFFF, 0, 32'h1, 0, 32'h1006);
        add_vec(7'h37, 32'd1, 32'hFFFF_FFFF, 0, 32'h0, 0, 32'h1006);
        add_vec(7'h40, 32'd7, 32'd9, 0, 32'h0, 0, 32'h1006);

        // reset for two idle cycles
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_val", bus.val_out, 32'h0);

        // table-driven vectors, back-to-back
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(0, 0, 1, 1, tbl[i].op, tbl[i].v1, tbl[i].v2, 5'((i % 31) + 1), tbl[i].pc);
            check($sformatf("tbl%0d_val", i), bus.val_out, tbl[i].exp_val);
            check($sformatf("tbl%0d_con", i), 32'(bus.alu2if_con), 32'(tbl[i].exp_con));
            check($sformatf("tbl%0d_pc", i), bus.alu2if_pc, tbl[i].exp_pc);
        end

        // idle drops aluReady, keeps value
        cyc(0, 0, 1, 0, 7'h10, 1, 1, 9, 0);

        // ADD then SUB back to back, then stall with a live execute
        cyc(0, 0, 1, 1, 7'h10, 32'd10, 32'd20, 5'd3, 0);
        check("b2b_add", bus.val_out, 32'd30);
        cyc(0, 0, 1, 1, 7'h11, 32'd10, 32'd20, 5'd4, 0);
        check("b2b_sub_tag", 32'(bus.entry_out), 32'd4);
        cyc(0, 0, 0, 1, 7'h10, 32'd1, 32'd1, 5'd7, 0);
        cyc(0, 1, 0, 1, 7'h10, 32'd1, 32'd1, 5'd7, 0);
        check("stall_frozen", bus.val_out, 32'hFFFF_FFF6);

        // JALR then flush with execute: outputs cleared
        cyc(0, 0, 1, 1, JALR, 32'h2001, 32'd0, 5'd8, 32'h40);
        cyc(0, 1, 1, 1, 7'h10, 32'd5, 32'd5, 5'd9, 0);
        check("flush_ready", 32'(bus.aluReady), 32'd0);

        // reset mid-stream drops the pending result
        cyc(0, 0, 1, 1, 7'h10, 32'd5, 32'd6, 5'd2, 0);
        cyc(1, 0, 1, 1, 7'h10, 32'd7, 32'd8, 5'd3, 0);
        cyc(0, 0, 1, 0, 7'h10, 0, 0, 0, 0);

        // random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, ops.size() - 1)];
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 9) < 7, op, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                5'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
